// File: rtl/pacman_pkg.sv
// Shared constants and types for the Pac-Man movement block: maze geometry,
// start tile, direction codes and the wall-lookup state machine encoding.
package pacman_pkg;

  localparam int TILE_SIZE = 16;
  localparam int MAZE_COLS = 28;
  localparam int MAZE_ROWS = 31;

  localparam logic [9:0] START_X  = 10'd208;
  localparam logic [9:0] START_Y  = 10'd368;
  localparam logic [9:0] TUNNEL_X = 10'd432;
  localparam logic [4:0] LAST_COL = 5'd27;
  localparam logic [4:0] LAST_ROW = 5'd30;

  localparam logic [2:0] DIR_STOP  = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b100;
  localparam logic [2:0] DIR_RIGHT = 3'b101;
  localparam logic [2:0] DIR_DOWN  = 3'b110;
  localparam logic [2:0] DIR_LEFT  = 3'b111;

  typedef enum logic [2:0] {
    L_UP    = 3'd0,
    L_RIGHT = 3'd1,
    L_DOWN  = 3'd2,
    L_LEFT  = 3'd3,
    L_FIN   = 3'd4,
    IDLE    = 3'd5
  } state_e;

  // Side index doubles as the adjacent_walls bit position
  typedef enum logic [1:0] {
    SIDE_UP    = 2'd0,
    SIDE_RIGHT = 2'd1,
    SIDE_DOWN  = 2'd2,
    SIDE_LEFT  = 2'd3
  } side_e;

endpackage

// File: rtl/pacman_mover_if.sv
// Maze wall ROM port: the mover drives the address, the ROM returns the
// wall bit one cycle later.
interface pacman_mover_if;
  logic [9:0] wall_addr;
  logic       wall_data;

  modport master (output wall_addr, input wall_data);
  modport slave  (input wall_addr, output wall_data);
endinterface

// File: rtl/pacman_tile_addr.sv
// Neighbour tile address for one side of (row, col), with horizontal tunnel
// wrap and a forced wall above the top row and below the bottom row.
module pacman_tile_addr
  import pacman_pkg::*;
(
  input  logic [4:0] row_i,
  input  logic [4:0] col_i,
  input  side_e      side_i,
  output logic [9:0] addr_o,
  output logic       force_wall_o
);

  logic [4:0] row_s;
  logic [4:0] col_s;

  always_comb begin
    row_s        = row_i;
    col_s        = col_i;
    force_wall_o = 1'b0;
    case (side_i)
      SIDE_UP: begin
        row_s        = row_i - 5'd1;
        force_wall_o = (row_i == 5'd0);
      end
      SIDE_RIGHT: col_s = (col_i == LAST_COL) ? 5'd0 : col_i + 5'd1;
      SIDE_DOWN: begin
        row_s        = row_i + 5'd1;
        force_wall_o = (row_i == LAST_ROW);
      end
      SIDE_LEFT: col_s = (col_i == 5'd0) ? LAST_COL : col_i - 5'd1;
      default: begin
        row_s = row_i;
        col_s = col_i;
      end
    endcase
  end

  // row*32 + col is a plain concatenation
  assign addr_o = {row_s, col_s};

endmodule

// File: rtl/pacman_mover.sv
// Moves the sprite one pixel per frame tick and refreshes the four
// surrounding wall bits from the maze ROM whenever it lands on a tile.
module pacman_mover
  import pacman_pkg::*;
(
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Restart,
  input  logic           frame_tick,
  input  logic [2:0]     direction,
  pacman_mover_if.master wall_if,
  output logic [9:0]     pacman_x,
  output logic [9:0]     pacman_y,
  output logic [3:0]     adjacent_walls,
  output logic           walls_valid
);

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [3:0] adj_q, adj_d;
  logic       pend_q, pend_d;
  logic       force_q;
  side_e      side_s;
  logic       force_s;
  logic       wall_bit_s;
  logic       aligned_s;
  logic       blocked_s;
  logic [9:0] step_x_s, step_y_s;
  logic       unused_s;

  pacman_tile_addr u_tile_addr (
    .row_i        (y_q[8:4]),
    .col_i        (x_q[8:4]),
    .side_i       (side_s),
    .addr_o       (wall_if.wall_addr),
    .force_wall_o (force_s)
  );

  always_comb begin
    case (state_q)
      L_RIGHT: side_s = SIDE_RIGHT;
      L_DOWN:  side_s = SIDE_DOWN;
      L_LEFT:  side_s = SIDE_LEFT;
      default: side_s = SIDE_UP;
    endcase
  end

  always_comb begin
    step_x_s = x_q;
    step_y_s = y_q;
    case (direction[1:0])
      2'd0:    step_y_s = y_q - 10'd1;
      2'd1:    step_x_s = (x_q == TUNNEL_X) ? 10'd0 : x_q + 10'd1;
      2'd2:    step_y_s = y_q + 10'd1;
      default: step_x_s = (x_q == 10'd0) ? TUNNEL_X : x_q - 10'd1;
    endcase
  end

  assign aligned_s  = (x_q[3:0] == 4'd0) && (y_q[3:0] == 4'd0);
  assign blocked_s  = aligned_s && adj_q[direction[1:0]];
  // The force flag belongs to the address issued last cycle, like wall_data
  assign wall_bit_s = wall_if.wall_data | force_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    adj_d   = adj_q;
    pend_d  = pend_q | frame_tick;
    case (state_q)
      L_UP:    state_d = L_RIGHT;
      L_RIGHT: begin adj_d[0] = wall_bit_s; state_d = L_DOWN;  end
      L_DOWN:  begin adj_d[1] = wall_bit_s; state_d = L_LEFT;  end
      L_LEFT:  begin adj_d[2] = wall_bit_s; state_d = L_FIN;   end
      L_FIN:   begin adj_d[3] = wall_bit_s; state_d = IDLE;    end
      IDLE: begin
        pend_d = 1'b0;
        if ((frame_tick || pend_q) && direction[2] && !blocked_s) begin
          x_d = step_x_s;
          y_d = step_y_s;
          if ((step_x_s[3:0] == 4'd0) && (step_y_s[3:0] == 4'd0)) begin
            state_d = L_UP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = L_UP;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset || Restart) begin
      state_q <= L_UP;
      x_q     <= START_X;
      y_q     <= START_Y;
      adj_q   <= 4'b0000;
      pend_q  <= 1'b0;
      force_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      adj_q   <= adj_d;
      pend_q  <= pend_d;
      force_q <= force_s;
    end
  end

  assign pacman_x       = x_q;
  assign pacman_y       = y_q;
  assign adjacent_walls = adj_q;
  assign walls_valid    = (state_q == IDLE);
  assign unused_s       = ^{x_q[9], y_q[9]};

endmodule

// File: tb/tb_pacman_mover.sv
// Directed and randomized bench for pacman_mover against a pixel/tile level
// reference model driven by a maze array that also serves as the wall ROM.
module tb_pacman_mover;
  import pacman_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Restart;
  logic       frame_tick;
  logic [2:0] direction;
  logic [9:0] pacman_x, pacman_y;
  logic [3:0] adjacent_walls;
  logic       walls_valid;

  pacman_mover_if wall_if ();

  bit maze [0:1023];
  int checks = 0;
  int errors = 0;
  int mx, my;
  logic [3:0] madj;

  always #5 Clk = ~Clk;

  always @(posedge Clk) wall_if.wall_data <= maze[wall_if.wall_addr];

  pacman_mover dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Restart        (Restart),
    .frame_tick     (frame_tick),
    .direction      (direction),
    .wall_if        (wall_if.master),
    .pacman_x       (pacman_x),
    .pacman_y       (pacman_y),
    .adjacent_walls (adjacent_walls),
    .walls_valid    (walls_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Walls around the tile containing pixel (x, y), straight from the maze rules
  function automatic logic [3:0] model_adj(input int x, input int y);
    int r  = y / TILE_SIZE;
    int c  = x / TILE_SIZE;
    int cl = (c == 0) ? MAZE_COLS - 1 : c - 1;
    int cr = (c == MAZE_COLS - 1) ? 0 : c + 1;
    logic [3:0] a;
    a[0] = (r == 0) ? 1'b1 : maze[(r - 1) * 32 + c];
    a[1] = maze[r * 32 + cr];
    a[2] = (r == MAZE_ROWS - 1) ? 1'b1 : maze[(r + 1) * 32 + c];
    a[3] = maze[r * 32 + cl];
    return a;
  endfunction

  task automatic model_tick(input logic [2:0] d, output bit relook);
    bit aligned = (mx % TILE_SIZE == 0) && (my % TILE_SIZE == 0);
    relook = 1'b0;
    if (d[2] && !(aligned && madj[d[1:0]])) begin
      case (d[1:0])
        2'd0:    my = my - 1;
        2'd1:    mx = (mx == 432) ? 0 : mx + 1;
        2'd2:    my = my + 1;
        default: mx = (mx == 0) ? 432 : mx - 1;
      endcase
      if ((mx % TILE_SIZE == 0) && (my % TILE_SIZE == 0)) begin
        madj   = model_adj(mx, my);
        relook = 1'b1;
      end
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (walls_valid !== 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check({tag, " valid"}, walls_valid, 1);
  endtask

  // Called at a negedge with the DUT idle; one tick, then compare to the model
  task automatic do_move(input logic [2:0] d, input string tag);
    bit relook;
    direction  = d;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    model_tick(d, relook);
    check({tag, " x"}, pacman_x, mx);
    check({tag, " y"}, pacman_y, my);
    if (relook) begin
      check({tag, " drop"}, walls_valid, 0);
      wait_valid(tag);
      check({tag, " adj"}, adjacent_walls, madj);
    end else begin
      check({tag, " hold"}, walls_valid, 1);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit relook;
    logic [2:0] d;
    int r;

    Reset = 1'b1; Restart = 1'b0; frame_tick = 1'b0; direction = DIR_STOP;
    foreach (maze[i]) maze[i] = 1'b0;
    maze[717] = 1'b1;
    maze[720] = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst x", pacman_x, 208);
    check("rst y", pacman_y, 368);
    check("rst valid", walls_valid, 0);
    check("rst adj", adjacent_walls, 0);

    // Lookup address sequence after reset release
    Reset = 1'b0;
    #1;
    check("addr up", wall_if.wall_addr, 717);
    @(negedge Clk); check("addr right", wall_if.wall_addr, 750);
    @(negedge Clk); check("addr down", wall_if.wall_addr, 781);
    @(negedge Clk); check("addr left", wall_if.wall_addr, 748);
    @(negedge Clk); check("fin valid", walls_valid, 0);
    @(negedge Clk); check("idle valid", walls_valid, 1);
    mx = 208; my = 368; madj = model_adj(mx, my);
    check("start adj", adjacent_walls, madj);

    // Blocked up: no move, no new lookup
    do_move(DIR_UP, "blocked");
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      check("blocked stay", walls_valid, 1);
    end

    // 16 steps right to the next tile, then a 5-cycle lookup
    for (int i = 0; i < 15; i++) do_move(DIR_RIGHT, "right");
    direction = DIR_RIGHT; frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    model_tick(DIR_RIGHT, relook);
    check("x224", pacman_x, 224);
    for (int i = 0; i < 5; i++) begin
      check("lookup low", walls_valid, 0);
      @(negedge Clk);
    end
    check("lookup high", walls_valid, 1);
    check("x224 adj", adjacent_walls, madj);

    // Two ticks during a lookup collapse into one move
    for (int i = 0; i < 15; i++) do_move(DIR_RIGHT, "right2");
    frame_tick = 1'b1;
    @(negedge Clk);
    model_tick(DIR_RIGHT, relook);
    check("x240", pacman_x, 240);
    @(negedge Clk); frame_tick = 1'b0;
    @(negedge Clk); frame_tick = 1'b1;
    @(negedge Clk); frame_tick = 1'b0;
    wait_valid("pend");
    check("pend x before", pacman_x, 240);
    model_tick(DIR_RIGHT, relook);
    @(negedge Clk);
    check("pend x after", pacman_x, mx);
    repeat (4) @(negedge Clk);
    check("pend single", pacman_x, 241);

    // Restart in L_DOWN of the lookup at x=256
    for (int i = 0; i < 14; i++) do_move(DIR_RIGHT, "right3");
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    check("x256", pacman_x, 256);
    @(negedge Clk);
    @(negedge Clk);
    check("in L_DOWN", wall_if.wall_addr, 784);
    check("partial up", adjacent_walls[0], 1);
    Restart = 1'b1;
    @(negedge Clk);
    check("rs x", pacman_x, 208);
    check("rs y", pacman_y, 368);
    check("rs adj", adjacent_walls, 0);
    check("rs valid", walls_valid, 0);
    check("rs addr", wall_if.wall_addr, 717);
    Restart = 1'b0;
    mx = 208; my = 368; madj = model_adj(mx, my);
    wait_valid("rs");
    check("rs adj done", adjacent_walls, madj);

    // To x=0, y=224, then left through the tunnel
    for (int i = 0; i < 208; i++) do_move(DIR_LEFT, "to x0");
    for (int i = 0; i < 144; i++) do_move(DIR_UP, "to y224");
    do_move(DIR_LEFT, "tunnel");
    check("tunnel x", pacman_x, 432);
    check("tunnel y", pacman_y, 224);

    // Up to the top row: the up side is a wall even with an open ROM
    for (int i = 0; i < 224; i++) do_move(DIR_UP, "to top");
    check("top adj up", adjacent_walls[0], 1);
    do_move(DIR_UP, "top blocked");
    do_move(3'b010, "stop code");

    // Random maze and random legal-axis commands
    foreach (maze[i]) maze[i] = ($urandom_range(0, 3) == 0);
    Restart = 1'b1;
    @(negedge Clk);
    Restart = 1'b0;
    mx = 208; my = 368; madj = model_adj(mx, my);
    wait_valid("rand rs");
    check("rand adj", adjacent_walls, madj);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) d = 3'($urandom_range(0, 3));
      else if (mx % TILE_SIZE != 0) d = r[0] ? DIR_RIGHT : DIR_LEFT;
      else if (my % TILE_SIZE != 0) d = r[0] ? DIR_UP : DIR_DOWN;
      else d = {1'b1, 2'($urandom_range(0, 3))};
      do_move(d, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
